// File: rtl/memory_access_unit_if.sv
// Data-memory bus between the memory access unit (master) and the data memory (slave).
// One dword-wide request channel with byte strobes and a single ready completion.
interface memory_access_unit_if #(
  parameter int SIZE = 64
);
  logic            mem_req;
  logic            mem_we;
  logic [SIZE-1:0] mem_addr;
  logic [SIZE-1:0] mem_wdata;
  logic [7:0]      mem_wstrb;
  logic [SIZE-1:0] mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory stage: runs one load/store per accepted start with byte-lane steering,
// sign/zero extension, misalignment and timeout faults, and stalls the core while busy.
module memory_access_unit #(
  parameter int SIZE    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [SIZE-1:0]      address,
  input  logic [SIZE-1:0]      write_data,
  output logic [SIZE-1:0]      read_data,
  output logic                 stall,
  output logic                 done,
  output logic                 fault,
  memory_access_unit_if.master mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Last ACCESS cycle index before the bus is declared dead.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  state_t          state_r;
  logic [15:0]     cnt_r;
  logic [2:0]      off_r;
  logic [1:0]      size_r;
  logic            sign_r;
  logic            req_r;
  logic            we_r;
  logic [SIZE-1:0] addr_r;
  logic [SIZE-1:0] wdata_r;
  logic [7:0]      wstrb_r;
  logic [SIZE-1:0] rdata_r;
  logic            done_r;
  logic            fault_r;

  logic [2:0]      off_s;
  logic            accept_s;
  logic            aligned_s;
  logic [7:0]      lane_s;
  logic [7:0]      wstrb_s;
  logic [SIZE-1:0] wdata_s;
  logic [SIZE-1:0] shifted_s;
  logic [SIZE-1:0] load_s;
  logic            stall_s;

  // Request decode: alignment check and store lane steering from the incoming address.
  always_comb begin
    off_s    = address[2:0];
    accept_s = start && (mem_read ^ mem_write);
    case (size)
      2'd0:    begin aligned_s = 1'b1;                lane_s = 8'h01 << off_s; end
      2'd1:    begin aligned_s = (off_s[0] == 1'b0);    lane_s = 8'h03 << off_s; end
      2'd2:    begin aligned_s = (off_s[1:0] == 2'b00); lane_s = 8'h0F << off_s; end
      2'd3:    begin aligned_s = (off_s == 3'b000);     lane_s = 8'hFF;          end
      default: begin aligned_s = 1'b0;                lane_s = 8'h00;          end
    endcase
    if (mem_write) begin
      wstrb_s = lane_s;
    end else begin
      wstrb_s = 8'h00;
    end
    wdata_s = write_data << {off_s, 3'b000};
  end

  // Load extraction: move the addressed lane down to bit 0, then truncate and extend.
  always_comb begin
    shifted_s = mem.mem_rdata >> {off_r, 3'b000};
    case (size_r)
      2'd0:    load_s = {{56{sign_r & shifted_s[7]}},  shifted_s[7:0]};
      2'd1:    load_s = {{48{sign_r & shifted_s[15]}}, shifted_s[15:0]};
      2'd2:    load_s = {{32{sign_r & shifted_s[31]}}, shifted_s[31:0]};
      2'd3:    load_s = shifted_s;
      default: load_s = shifted_s;
    endcase
  end

  // Stall is combinational so the core freezes in the very cycle a request is accepted.
  always_comb begin
    if (state_r == ACCESS) begin
      stall_s = 1'b1;
    end else if (state_r == IDLE) begin
      stall_s = accept_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Access sequencer with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      off_r   <= 3'd0;
      size_r  <= 2'd0;
      sign_r  <= 1'b0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= 8'h00;
      rdata_r <= '0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          if (accept_s && aligned_s) begin
            off_r   <= off_s;
            size_r  <= size;
            sign_r  <= sign_ext;
            we_r    <= mem_write;
            addr_r  <= {address[SIZE-1:3], 3'b000};
            wdata_r <= wdata_s;
            wstrb_r <= wstrb_s;
            req_r   <= 1'b1;
            cnt_r   <= 16'd0;
            state_r <= ACCESS;
          end else if (accept_s) begin
            // Misaligned: fault immediately without touching the bus.
            done_r  <= 1'b1;
            fault_r <= 1'b1;
            state_r <= RESP;
          end
        end
        ACCESS: begin
          cnt_r <= cnt_r + 16'd1;
          if (mem.mem_ready) begin
            if (!we_r) begin
              rdata_r <= load_s;
            end
            req_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= RESP;
          end else if (TO_EN && (cnt_r == TO_LAST)) begin
            req_r   <= 1'b0;
            done_r  <= 1'b1;
            fault_r <= 1'b1;
            state_r <= RESP;
          end
        end
        RESP: begin
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          req_r   <= 1'b0;
          done_r  <= 1'b0;
          fault_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req   = req_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = addr_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_wstrb = wstrb_r;
  assign read_data     = rdata_r;
  assign done          = done_r;
  assign fault         = fault_r;
  assign stall         = stall_s;

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized bench for memory_access_unit against a transaction-level reference model.
// Directed scenarios first, then random loads/stores with random memory latency.
module tb_memory_access_unit;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        stall;
  logic        done;
  logic        fault;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] mdl_rd  = 64'd0;

  memory_access_unit_if #(.SIZE(64)) bus ();

  memory_access_unit #(.SIZE(64), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .size       (size),
    .sign_ext   (sign_ext),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Load result: gather n bytes starting at byte off, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdat, input int off, input int n,
                                           input logic sx);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdat[8*(off+i) +: 8];
    if (sx && v[8*n-1]) begin
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic scramble_inputs();
    start      = 1'($urandom_range(0, 1));
    mem_read   = 1'($urandom_range(0, 1));
    mem_write  = 1'($urandom_range(0, 1));
    size       = 2'($urandom_range(0, 3));
    sign_ext   = 1'($urandom_range(0, 1));
    address    = {$urandom(), $urandom()};
    write_data = {$urandom(), $urandom()};
  endtask

  task automatic check_quiet(input string tag);
    check_value({tag, "_req"},   64'(bus.mem_req), 64'd0);
    check_value({tag, "_done"},  64'(done),        64'd0);
    check_value({tag, "_fault"}, 64'(fault),       64'd0);
    check_value({tag, "_stall"}, 64'(stall),       64'd0);
    check_value({tag, "_rdata"}, read_data,        mdl_rd);
  endtask

  // One access; lat = ACCESS cycles before mem_ready (lat >= TIMEOUT means never ready).
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdat, input int lat);
    int          n;
    int          off;
    logic        valid;
    logic        algn;
    logic        exp_flt;
    logic        fin;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wd;
    int          k;
    n        = 1 << sz;
    off      = int'(addr[2:0]);
    valid    = rd ^ wr;
    algn     = (off % n) == 0;
    exp_strb = 8'h00;
    if (wr && algn) begin
      for (int i = 0; i < n; i++) exp_strb[off+i] = 1'b1;
    end
    exp_wd = wd << (8 * off);

    @(negedge clk);
    start = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
    address = addr; write_data = wd; bus.mem_ready = 1'b0;
    #1 check_value("stall_accept", 64'(stall), 64'(valid));
    @(negedge clk);
    start = 1'b0;
    #1;
    if (!valid) begin
      check_quiet("ignored");
      return;
    end
    if (!algn) begin
      check_value("misalign_done",  64'(done),        64'd1);
      check_value("misalign_fault", 64'(fault),       64'd1);
      check_value("misalign_req",   64'(bus.mem_req), 64'd0);
      check_value("misalign_stall", 64'(stall),       64'd0);
      check_value("misalign_rdata", read_data,        mdl_rd);
      @(negedge clk);
      #1 check_quiet("misalign_after");
      return;
    end
    k = 0; exp_flt = 1'b0; fin = 1'b0;
    while (!fin) begin
      check_value("acc_req",   64'(bus.mem_req),   64'd1);
      check_value("acc_we",    64'(bus.mem_we),    64'(wr));
      check_value("acc_addr",  bus.mem_addr,       {addr[63:3], 3'b000});
      check_value("acc_wstrb", 64'(bus.mem_wstrb), 64'(exp_strb));
      check_value("acc_wdata", bus.mem_wdata,      exp_wd);
      check_value("acc_stall", 64'(stall),         64'd1);
      check_value("acc_done",  64'(done),          64'd0);
      scramble_inputs();
      if (k == lat) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = rdat; fin = 1'b1;
      end else begin
        bus.mem_ready = 1'b0; bus.mem_rdata = {$urandom(), $urandom()};
        if (k == TIMEOUT - 1) begin
          exp_flt = 1'b1; fin = 1'b1;
        end
      end
      k++;
      @(negedge clk);
    end
    if (!exp_flt && rd) mdl_rd = ref_load(rdat, off, n, sx);
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = {$urandom(), $urandom()};
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd0;
    #1;
    check_value("resp_done",  64'(done),        64'd1);
    check_value("resp_fault", 64'(fault),       64'(exp_flt));
    check_value("resp_req",   64'(bus.mem_req), 64'd0);
    check_value("resp_stall", 64'(stall),       64'd0);
    check_value("resp_rdata", read_data,        mdl_rd);
    @(negedge clk);
    start = 1'b0; bus.mem_ready = 1'b0;
    #1 check_quiet("idle_after");
  endtask

  initial begin
    logic        rd;
    logic        wr;
    logic [63:0] a;
    reset = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0;
    sign_ext = 1'b0; address = 64'd0; write_data = 64'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check_value("reset_addr", bus.mem_addr, 64'd0);
    reset = 1'b1;

    // LDURB sign-extended from the top of byte lane 3.
    run_txn(1'b1, 1'b0, 2'd0, 1'b1, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 0);
    check_value("t1_result", read_data, 64'hFFFF_FFFF_FFFF_FF80);
    // STURH into the top half-word after three wait cycles.
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'h1234_ABCD, 64'd0, 3);
    // Misaligned dword load.
    run_txn(1'b1, 1'b0, 2'd3, 1'b0, 64'h1004, 64'd0, 64'd0, 0);
    // LDURSW that never gets mem_ready.
    run_txn(1'b1, 1'b0, 2'd2, 1'b1, 64'h3004, 64'd0, 64'd0, 99);
    // Both read and write set: ignored.
    run_txn(1'b1, 1'b1, 2'd3, 1'b0, 64'h4000, 64'd0, 64'd0, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; size = 2'd3; address = 64'h5000;
    @(negedge clk);
    start = 1'b0;
    #1 check_value("mid_req", 64'(bus.mem_req), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    mdl_rd = 64'd0;
    #1 check_quiet("mid_reset");
    check_value("mid_reset_we",    64'(bus.mem_we),    64'd0);
    check_value("mid_reset_addr",  bus.mem_addr,       64'd0);
    check_value("mid_reset_wdata", bus.mem_wdata,      64'd0);
    check_value("mid_reset_wstrb", 64'(bus.mem_wstrb), 64'd0);
    reset = 1'b1;
    run_txn(1'b1, 1'b0, 2'd2, 1'b1, 64'h6004, 64'd0, 64'h8000_0000_0000_0000, 0);
    check_value("t5_result", read_data, 64'hFFFF_FFFF_8000_0000);

    for (int t = 0; t < 250; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) wr = ~rd;
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'($urandom_range(0, 1) * 4);
      run_txn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
              {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
